// File: rtl/bin_to_bcd_seq_if.sv
// Conversion request/result bundle for bin_to_bcd_seq.
//
// Handshake: the requester raises start with value; the converter accepts it
// on any rising edge where busy is low (IDLE, or the single done cycle). A
// start seen while busy is high is dropped, not queued. done is a one-cycle
// pulse marking the cycle in which bcd/blank first show the new result. Both
// then hold until the next done.
//
// Signals:
//   start  requester -> converter  request a conversion of value
//   value  requester -> converter  unsigned operand, WIDTH bits
//   busy   converter -> requester  conversion in progress
//   done   converter -> requester  single-cycle result strobe
//   bcd    converter -> requester  DIGITS packed BCD digits, digit 0 = ones
//   blank  converter -> requester  leading-zero mask, bit k per digit k
interface bin_to_bcd_seq_if #(
  parameter int WIDTH  = 8,
  parameter int DIGITS = 3
);
  logic                  start;
  logic [WIDTH-1:0]      value;
  logic                  busy;
  logic                  done;
  logic [4*DIGITS-1:0]   bcd;
  logic [DIGITS-1:0]     blank;

  modport master (
    output start, value,
    input  busy, done, bcd, blank
  );

  modport slave (
    input  start, value,
    output busy, done, bcd, blank
  );
endinterface

// File: rtl/bin_to_bcd_seq.sv
// Sequential binary-to-BCD converter (shift-and-add-3), one input bit per
// clock. Produces registered BCD digits plus a leading-zero blanking mask
// for the seven-segment path.
//
// Ports:
//   clk      system clock, rising edge
//   reset    synchronous, active-high
//   conv     bin_to_bcd_seq_if.slave: start/value in, busy/done/bcd/blank out
//   state_o  current FSM state (IDLE=0, SHIFT=1, DONE=2) for observation
module bin_to_bcd_seq #(
  parameter int WIDTH  = 8,
  parameter int DIGITS = 3
) (
  input  logic              clk,
  input  logic              reset,
  bin_to_bcd_seq_if.slave   conv,
  output logic [1:0]        state_o
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam int BW = 4 * DIGITS;
  localparam int PW = WIDTH + 4 * DIGITS + 1;
  // Every digit blanked except the ones digit.
  localparam logic [DIGITS-1:0] BLANK_RST = ~DIGITS'(1);

  // 10^DIGITS must reach 2^WIDTH so the largest operand fits. PW bits hold
  // both sides since 10^D < 2^(4D).
  function automatic bit digits_fit();
    logic [PW-1:0] pow10;
    logic [PW-1:0] lim;
    pow10 = PW'(1);
    for (int i = 0; i < DIGITS; i++) pow10 = PW'(pow10 * PW'(10));
    lim = '0;
    lim[WIDTH] = 1'b1;
    return pow10 >= lim;
  endfunction

  if (!digits_fit()) begin : g_bad_params
    $error("bin_to_bcd_seq: DIGITS too small for WIDTH");
  end

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_e;

  state_e              state_q, state_d;
  logic [WIDTH-1:0]    sh_q, sh_d;
  logic [BW-1:0]       scr_q, scr_d;
  logic [CW-1:0]       cnt_q, cnt_d;
  logic [BW-1:0]       bcd_q, bcd_d;
  logic [DIGITS-1:0]   blank_q, blank_d;

  logic [BW-1:0]       scr_adj;
  logic [BW-1:0]       scr_shift;
  logic [DIGITS-1:0]   blank_calc;
  logic                zero_run;

  // Add-3 correction on each digit independently; no carry between digits.
  always_comb begin
    scr_adj = scr_q;
    for (int k = 0; k < DIGITS; k++) begin
      if (scr_q[4*k +: 4] >= 4'd5) scr_adj[4*k +: 4] = scr_q[4*k +: 4] + 4'd3;
    end
  end

  // Operand MSB enters the LSB of the ones digit.
  assign scr_shift = {scr_adj[BW-2:0], sh_q[WIDTH-1]};

  // Walk from the top digit down; a digit is blanked while everything above
  // it (inclusive) is still zero. The ones digit is never blanked.
  always_comb begin
    blank_calc = '0;
    zero_run   = 1'b1;
    for (int k = DIGITS - 1; k >= 1; k--) begin
      zero_run      = zero_run & (scr_shift[4*k +: 4] == 4'd0);
      blank_calc[k] = zero_run;
    end
  end

  always_comb begin
    state_d = state_q;
    sh_d    = sh_q;
    scr_d   = scr_q;
    cnt_d   = cnt_q;
    bcd_d   = bcd_q;
    blank_d = blank_q;
    unique case (state_q)
      IDLE, DONE: begin
        state_d = IDLE;
        if (conv.start) begin
          sh_d    = conv.value;
          scr_d   = '0;
          cnt_d   = CW'(WIDTH);
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        scr_d = scr_shift;
        sh_d  = sh_q << 1;
        cnt_d = cnt_q - CW'(1);
        // Last shift: publish the finished digits straight from the shifter
        // so they are visible in the done cycle.
        if (cnt_q == CW'(1)) begin
          bcd_d   = scr_shift;
          blank_d = blank_calc;
          state_d = DONE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      sh_q    <= '0;
      scr_q   <= '0;
      cnt_q   <= '0;
      bcd_q   <= '0;
      blank_q <= BLANK_RST;
    end else begin
      state_q <= state_d;
      sh_q    <= sh_d;
      scr_q   <= scr_d;
      cnt_q   <= cnt_d;
      bcd_q   <= bcd_d;
      blank_q <= blank_d;
    end
  end

  assign conv.busy  = (state_q == SHIFT);
  assign conv.done  = (state_q == DONE);
  assign conv.bcd   = bcd_q;
  assign conv.blank = blank_q;
  assign state_o    = state_q;

endmodule

// File: tb/tb_bin_to_bcd_seq.sv
// Bench for bin_to_bcd_seq: an 8-bit/3-digit and a 16-bit/5-digit instance
// share clock and reset. Expected digits and blank masks come from decimal
// arithmetic on the operand.
module tb_bin_to_bcd_seq;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  bin_to_bcd_seq_if #(.WIDTH(8),  .DIGITS(3)) s_if ();
  bin_to_bcd_seq_if #(.WIDTH(16), .DIGITS(5)) w_if ();
  logic [1:0] s_state, w_state;

  bin_to_bcd_seq #(.WIDTH(8), .DIGITS(3)) u_small (
    .clk(clk), .reset(reset), .conv(s_if), .state_o(s_state)
  );
  bin_to_bcd_seq #(.WIDTH(16), .DIGITS(5)) u_wide (
    .clk(clk), .reset(reset), .conv(w_if), .state_o(w_state)
  );

  int tests_run;
  int tests_failed;
  logic [19:0] exp_q[$];

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- reference model ----------------
  function automatic logic [19:0] ref_bcd(input int v, input int nd);
    logic [19:0] r;
    int x;
    r = '0;
    x = v;
    for (int k = 0; k < nd; k++) begin
      r[4*k +: 4] = 4'(x % 10);
      x = x / 10;
    end
    return r;
  endfunction

  function automatic logic [4:0] ref_blank(input int v, input int nd);
    logic [4:0] b;
    b = '0;
    for (int k = 1; k < nd; k++) if (v < 10 ** k) b[k] = 1'b1;
    return b;
  endfunction

  // ---------------- DUT access ----------------
  function automatic logic get_done(input bit wide);
    return wide ? w_if.done : s_if.done;
  endfunction
  function automatic logic get_busy(input bit wide);
    return wide ? w_if.busy : s_if.busy;
  endfunction
  function automatic logic [19:0] get_bcd(input bit wide);
    return wide ? w_if.bcd : {8'd0, s_if.bcd};
  endfunction
  function automatic logic [4:0] get_blank(input bit wide);
    return wide ? w_if.blank : {2'b00, s_if.blank};
  endfunction

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input bit wide, input logic st, input logic [15:0] v);
    if (wide) begin
      w_if.start = st;
      w_if.value = v;
    end else begin
      s_if.start = st;
      s_if.value = v[7:0];
    end
  endtask

  // Present start for one edge, then scramble value (don't-care afterwards).
  task automatic launch(input bit wide, input logic [15:0] v);
    drive(wide, 1'b1, v);
    step();
    drive(wide, 1'b0, 16'($urandom));
  endtask

  // Called in the first cycle after the accepting edge (cycle 1). Returns in
  // the done cycle without stepping past it.
  task automatic wait_done(input bit wide, output int cyc, output int busy_low,
                           output bit seen);
    cyc = 1;
    busy_low = 0;
    seen = 1'b0;
    while (!seen && cyc <= 60) begin
      if (get_done(wide)) seen = 1'b1;
      else begin
        if (get_busy(wide) !== 1'b1) busy_low++;
        step();
        cyc++;
      end
    end
  endtask

  // One full conversion with all result checks.
  task automatic convert(input bit wide, input int v, input string tag);
    int cyc, busy_low, nd, lat;
    bit seen;
    logic [19:0] exp_bcd;
    logic [4:0]  exp_blank;
    nd  = wide ? 5 : 3;
    lat = wide ? 17 : 9;
    exp_q.push_back(ref_bcd(v, nd));
    launch(wide, 16'(v));
    wait_done(wide, cyc, busy_low, seen);
    exp_bcd   = exp_q.pop_front();
    exp_blank = ref_blank(v, nd);
    tests_run++;
    if (!seen) begin
      tests_failed++;
      $display("FAIL %s timeout: no done for value %0d", tag, v);
      return;
    end
    if (cyc !== lat) begin
      tests_failed++;
      $display("FAIL %s latency: value %0d got %0d cycles want %0d", tag, v, cyc, lat);
    end
    tests_run++;
    if (get_bcd(wide) !== exp_bcd) begin
      tests_failed++;
      $display("FAIL %s bcd: value %0d got %h want %h", tag, v, get_bcd(wide), exp_bcd);
    end
    tests_run++;
    if (get_blank(wide) !== exp_blank) begin
      tests_failed++;
      $display("FAIL %s blank: value %0d got %b want %b", tag, v, get_blank(wide), exp_blank);
    end
    tests_run++;
    if (busy_low !== 0 || get_busy(wide) !== 1'b0) begin
      tests_failed++;
      $display("FAIL %s busy: value %0d low-while-shifting %0d, busy-at-done %b want 0/0",
               tag, v, busy_low, get_busy(wide));
    end
    step();
    tests_run++;
    if (get_done(wide) !== 1'b0) begin
      tests_failed++;
      $display("FAIL %s done_width: value %0d done high two cycles", tag, v);
    end
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    int dones, busies;
    reset = 1'b1;
    drive(1'b0, 1'b0, 16'd0);
    drive(1'b1, 1'b0, 16'd0);
    repeat (3) step();
    reset = 1'b0;
    dones = 0;
    busies = 0;
    for (int i = 0; i < 20; i++) begin
      if (s_if.done) dones++;
      if (s_if.busy) busies++;
      step();
    end
    tests_run++;
    if (dones !== 0 || busies !== 0) begin
      tests_failed++;
      $display("FAIL reset_idle: done pulses %0d busy cycles %0d want 0/0", dones, busies);
    end
    tests_run++;
    if (s_if.bcd !== 12'h000 || s_if.blank !== 3'b110) begin
      tests_failed++;
      $display("FAIL reset_small: bcd %h blank %b want 000/110", s_if.bcd, s_if.blank);
    end
    tests_run++;
    if (w_if.bcd !== 20'h00000 || w_if.blank !== 5'b11110 || w_if.busy !== 1'b0) begin
      tests_failed++;
      $display("FAIL reset_wide: bcd %h blank %b busy %b want 00000/11110/0",
               w_if.bcd, w_if.blank, w_if.busy);
    end
  endtask

  task automatic test_exhaustive_8();
    int order[256];
    int j, t;
    for (int i = 0; i < 256; i++) order[i] = i;
    for (int i = 255; i > 0; i--) begin
      j = $urandom_range(i, 0);
      t = order[i];
      order[i] = order[j];
      order[j] = t;
    end
    for (int i = 0; i < 256; i++) begin
      repeat ($urandom_range(2, 0)) step();
      convert(1'b0, order[i], "exh8");
    end
  endtask

  task automatic test_back_to_back();
    int cyc, busy_low;
    bit seen;
    launch(1'b0, 16'd42);
    wait_done(1'b0, cyc, busy_low, seen);
    tests_run++;
    if (!seen || s_if.bcd !== 12'h042 || s_if.busy !== 1'b0) begin
      tests_failed++;
      $display("FAIL b2b_first: seen %b bcd %h busy %b want 1/042/0", seen, s_if.bcd, s_if.busy);
    end
    // Start the next conversion from inside the done cycle.
    launch(1'b0, 16'd199);
    wait_done(1'b0, cyc, busy_low, seen);
    tests_run++;
    if (!seen || cyc !== 9 || busy_low !== 0) begin
      tests_failed++;
      $display("FAIL b2b_second_timing: seen %b cycles %0d busy-low %0d want 1/9/0",
               seen, cyc, busy_low);
    end
    tests_run++;
    if (s_if.bcd !== 12'h199 || s_if.blank !== 3'b000) begin
      tests_failed++;
      $display("FAIL b2b_second: bcd %h blank %b want 199/000", s_if.bcd, s_if.blank);
    end
    step();
  endtask

  task automatic test_start_ignored();
    int dones;
    logic [11:0] got;
    launch(1'b0, 16'd128);
    step();
    drive(1'b0, 1'b1, 16'd5);
    step();
    drive(1'b0, 1'b0, 16'd0);
    dones = 0;
    got = '0;
    for (int i = 0; i < 30; i++) begin
      if (s_if.done) begin
        dones++;
        got = s_if.bcd;
      end
      step();
    end
    tests_run++;
    if (dones !== 1 || got !== 12'h128 || s_if.bcd !== 12'h128) begin
      tests_failed++;
      $display("FAIL ignored_start: dones %0d bcd %h want 1/128", dones, got);
    end
  endtask

  task automatic test_reset_mid();
    int dones;
    launch(1'b0, 16'd250);
    repeat (3) step();
    // Reset together with a start request: reset must win.
    reset = 1'b1;
    drive(1'b0, 1'b1, 16'd77);
    step();
    reset = 1'b0;
    drive(1'b0, 1'b0, 16'd0);
    dones = 0;
    for (int i = 0; i < 20; i++) begin
      if (s_if.done || s_if.busy) dones++;
      step();
    end
    tests_run++;
    if (dones !== 0 || s_if.bcd !== 12'h000 || s_if.blank !== 3'b110) begin
      tests_failed++;
      $display("FAIL reset_mid: activity %0d bcd %h blank %b want 0/000/110",
               dones, s_if.bcd, s_if.blank);
    end
    convert(1'b0, 13, "after_reset");
  endtask

  task automatic test_wide();
    convert(1'b1, 65535, "wide");
    convert(1'b1, 0, "wide");
    convert(1'b1, 1000, "wide");
    convert(1'b1, 9, "wide");
    for (int i = 0; i < 20; i++) begin
      repeat ($urandom_range(3, 0)) step();
      convert(1'b1, int'($urandom_range(65535, 0)), "wide_rand");
    end
  endtask

  // ---------------- main sequence / report ----------------
  initial begin
    tests_run = 0;
    tests_failed = 0;
    test_reset();
    test_exhaustive_8();
    test_back_to_back();
    test_start_ignored();
    test_reset_mid();
    test_wide();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
